fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core, directly upstream of decode. Holds the fetch PC, issues one-outstanding-request reads to instruction memory over a req/gnt/rvalid handshake, and owns the IF/ID pipeline register. Its `InstrD` feeds the decode control unit: `Op` = `InstrD[31:26]`, `shamt` = `InstrD[10:6]`, `funct` = `InstrD[5:0]`. Stall, flush and redirect (jump/branch) inputs come from decode and the hazard logic.

---
 rtl/fetch_pkg.sv | 46 ++++
 rtl/ifid_reg.sv | 71 +++++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state type, the bubble instruction, the default reset
// PC, the IF/ID payload struct, and the Op/shamt/funct field positions that
// decode uses to slice InstrD.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Instruction field slice positions shared with decode
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } fetch_state_e;

    // Fetched instruction together with the PC it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    function automatic logic [OP_MSB-OP_LSB:0] instr_op(input logic [XLEN-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [SHAMT_MSB-SHAMT_LSB:0] instr_shamt(input logic [XLEN-1:0] instr);
        return instr[SHAMT_MSB:SHAMT_LSB];
    endfunction

    function automatic logic [FUNCT_MSB-FUNCT_LSB:0] instr_funct(input logic [XLEN-1:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with flush > stall > load priority.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush_i            replace contents with a bubble (PC fields hold)
//   stall_i            hold all fields
//   load_i, word_i     load a fetched {instr, pc}
//   instr_o, pc_o, pc_plus4_o, valid_o   registered IF/ID contents
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  fetch_word_t     word_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    // Next contents; no load and no stall inserts a bubble
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_i) begin
            // hold
        end else if (load_i) begin
            instr_d    = word_i.instr;
            pc_d       = word_i.pc;
            pc_plus4_d = word_i.pc + XLEN'(4);
            valid_d    = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Holds PCF, issues one
// outstanding req/gnt/rvalid read at a time, and owns the IF/ID register.
// Ports:
//   clk, rst                       clock, async active-low reset
//   StallD, FlushD                 IF/ID hold / bubble from hazard logic
//   Redirect, RedirectPC           jump/branch target
//   imem_req, imem_addr            read request, address (= PCF)
//   imem_gnt, imem_rvalid, imem_rdata   memory handshake and data
//   InstrD, PCD, PCPlus4D, ValidD  IF/ID outputs to decode
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    fetch_word_t     skid_q, skid_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] pcf_plus4;
    logic            load_c;
    fetch_word_t     load_word_c;

    assign pcf_plus4 = pcf_q + XLEN'(4);

    // Fetch FSM: next state, PCF, skid buffer and IF/ID load request
    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        skid_d      = skid_q;
        load_c      = 1'b0;
        load_word_c = '{instr: imem_rdata, pc: pcf_q};
        case (state_q)
            ST_IDLE: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (Redirect) pcf_d = RedirectPC;
                if (imem_gnt) state_d = Redirect ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (Redirect) begin
                    // a response in this same cycle is wrong-path and dropped
                    pcf_d   = RedirectPC;
                    state_d = imem_rvalid ? ST_ISSUE : ST_DROP;
                end else if (imem_rvalid) begin
                    if (FlushD) begin
                        state_d = ST_ISSUE;
                    end else if (StallD) begin
                        skid_d  = '{instr: imem_rdata, pc: pcf_q};
                        state_d = ST_HOLD;
                    end else begin
                        load_c  = 1'b1;
                        pcf_d   = pcf_plus4;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_HOLD: begin
                if (Redirect) begin
                    pcf_d   = RedirectPC;
                    state_d = ST_ISSUE;
                end else if (FlushD) begin
                    // skid word is younger than the flushed one; refetch it
                    state_d = ST_ISSUE;
                end else if (!StallD) begin
                    load_c      = 1'b1;
                    load_word_c = skid_q;
                    pcf_d       = pcf_plus4;
                    state_d     = ST_ISSUE;
                end
            end
            ST_DROP: begin
                if (Redirect)    pcf_d   = RedirectPC;
                if (imem_rvalid) state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
        req_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pcf_q   <= RESET_PC;
            skid_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            skid_q  <= skid_d;
            req_q   <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pcf_q;

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst_n      (rst),
        .flush_i    (FlushD),
        .stall_i    (StallD),
        .load_i     (load_c),
        .word_i     (load_word_c),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. The stimulus process plays
// instruction memory and pushes each word that decode should see into a
// queue; a monitor pops and compares whenever a new IF/ID entry appears.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD, FlushD, Redirect;
    logic [31:0] RedirectPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        mon_prev_v  = 1'b0;
    logic [31:0] mon_prev_pc = '0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) for a request, then check its address
    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("imem_req_seen", 32'(imem_req), 32'd1);
        chk("imem_addr", imem_addr, addr);
    endtask

    task automatic grant();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    // One complete fetch whose word decode must receive
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int gwait, input int rwait);
        exp_t e;
        wait_req(addr);
        repeat (gwait) @(negedge clk);
        grant();
        repeat (rwait) @(negedge clk);
        e.instr = data;
        e.pc    = addr;
        e.pc4   = 32'(addr + 32'd4);
        sb.push_back(e);
        respond(data);
    endtask

    // Monitor: a new IF/ID entry is a rising ValidD or a changed PCD
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ValidD === 1'b1 && (!mon_prev_v || PCD !== mon_prev_pc)) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_load: got InstrD %h PCD %h expected none @%0t",
                             InstrD, PCD, $time);
                end else begin
                    e = sb.pop_front();
                    chk("InstrD", InstrD, e.instr);
                    chk("PCD", PCD, e.pc);
                    chk("PCPlus4D", PCPlus4D, e.pc4);
                end
            end
            mon_prev_v  = (rst === 1'b1) && (ValidD === 1'b1);
            mon_prev_pc = PCD;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; Redirect = 1'b0;
        RedirectPC = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_InstrD", InstrD, 32'h0);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_ValidD", 32'(ValidD), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Sequential fetches, including extra grant/data wait cycles
        fetch(32'h0, 32'h2001_0001, 0, 0);
        fetch(32'h4, 32'h2002_0002, 0, 0);
        fetch(32'h8, 32'h0022_1820, 2, 1);

        // Data returns under a 3-cycle stall: held in skid, no new request
        wait_req(32'hC);
        grant();
        StallD = 1'b1;
        begin
            exp_t e;
            e.instr = 32'h2008_0005; e.pc = 32'hC; e.pc4 = 32'h10;
            sb.push_back(e);
        end
        respond(32'h2008_0005);
        chk("hold_req1", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("hold_req2", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("hold_req3", 32'(imem_req), 32'd0);
        StallD = 1'b0;
        @(negedge clk);
        chk("skid_InstrD", InstrD, 32'h2008_0005);
        chk("skid_PCD", PCD, 32'hC);
        chk("skid_next_addr", imem_addr, 32'h10);

        // Flush together with stall while a word sits in the skid buffer
        fetch(32'h10, 32'h8C43_0000, 0, 0);
        wait_req(32'h14);
        StallD = 1'b1;
        grant();
        respond(32'hAC43_0004);
        chk("stall_ValidD", 32'(ValidD), 32'd1);
        chk("stall_InstrD", InstrD, 32'h8C43_0000);
        FlushD = 1'b1;
        @(negedge clk);
        FlushD = 1'b0;
        StallD = 1'b0;
        chk("flush_ValidD", 32'(ValidD), 32'd0);
        chk("flush_InstrD", InstrD, 32'h0);
        chk("flush_PCD", PCD, 32'h10);
        Redirect = 1'b1; RedirectPC = 32'h200;
        @(negedge clk);
        Redirect = 1'b0;
        fetch(32'h200, 32'h0800_0040, 0, 0);

        // Redirect during WAIT: late word dropped, next request at target
        wait_req(32'h204);
        grant();
        Redirect = 1'b1; RedirectPC = 32'h100;
        @(negedge clk);
        Redirect = 1'b0;
        chk("drop_req", 32'(imem_req), 32'd0);
        chk("drop_addr", imem_addr, 32'h100);
        respond(32'hDEAD_0001);
        chk("drop_ValidD", 32'(ValidD), 32'd0);
        wait_req(32'h100);

        // Redirect in the same cycle as rvalid in WAIT
        grant();
        Redirect = 1'b1; RedirectPC = 32'h300;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0002;
        @(negedge clk);
        Redirect = 1'b0; imem_rvalid = 1'b0;
        chk("wrv_ValidD", 32'(ValidD), 32'd0);
        wait_req(32'h300);

        // Redirect with grant in ISSUE: DROP, then request the target
        imem_gnt = 1'b1; Redirect = 1'b1; RedirectPC = 32'h400;
        @(negedge clk);
        imem_gnt = 1'b0; Redirect = 1'b0;
        chk("igr_req1", 32'(imem_req), 32'd0);
        chk("igr_addr", imem_addr, 32'h400);
        @(negedge clk);
        chk("igr_req2", 32'(imem_req), 32'd0);
        respond(32'hDEAD_0003);
        chk("igr_ValidD", 32'(ValidD), 32'd0);
        fetch(32'h400, 32'h2404_0400, 0, 0);

        // Asynchronous reset while in WAIT
        StallD = 1'b1;
        wait_req(32'h404);
        grant();
        chk("pre_rst_ValidD", 32'(ValidD), 32'd1);
        chk("pre_rst_PCD", PCD, 32'h400);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_InstrD", InstrD, 32'h0);
        chk("arst_PCD", PCD, 32'h0);
        chk("arst_PCPlus4D", PCPlus4D, 32'h0);
        chk("arst_ValidD", 32'(ValidD), 32'd0);
        StallD = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0004;
        @(negedge clk);
        chk("stray1_ValidD", 32'(ValidD), 32'd0);
        chk("post_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("stray2_ValidD", 32'(ValidD), 32'd0);
        fetch(32'h0, 32'h1111_0000, 0, 0);

        // PC wrap at the top of the address space
        wait_req(32'h4);
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        @(negedge clk);
        Redirect = 1'b0;
        fetch(32'hFFFF_FFFC, 32'h03E0_0008, 0, 1);
        wait_req(32'h0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
